instr_ctrl: RTL

- Instruction register and control-word generator for the 16-bit processor.
- Sits directly downstream of the one-hot tick_FSM and consumes its tick[3:0].
- Latches the instruction from the bus at T0 and decodes opcode/rx/ry/imm.
- Drives the per-tick register-file, ALU and memory strobes, and closes each instruction with done, which restarts the tick sequence.

---
 rtl/instr_ctrl_pkg.sv | 41 ++++
 rtl/instr_ctrl_if.sv | 41 ++++
 rtl/instr_ctrl_dec.sv | 8 +
 rtl/sign_ext.sv | 10 +
 rtl/instr_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/instr_ctrl_pkg.sv
// Shared definitions for the instruction register / control-word generator:
// opcodes, instruction field positions and tick indices.
package instr_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 16;

    typedef enum logic [2:0] {
        OP_MV   = 3'd0,
        OP_MVI  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_LD   = 3'd4,
        OP_ST   = 3'd5,
        OP_MVNZ = 3'd6,
        OP_ADDI = 3'd7
    } opcode_t;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 13;
    localparam int RX_MSB = 12;
    localparam int RX_LSB = 9;
    localparam int RY_MSB = 8;
    localparam int RY_LSB = 5;
    localparam int IMM_W  = 9;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    // Final tick of each opcode; any later tick is treated as illegal.
    function automatic logic [1:0] last_tick(opcode_t op);
        case (op)
            OP_MV, OP_MVI, OP_MVNZ: return T1;
            OP_ST:                  return T2;
            default:                return T3;
        endcase
    endfunction

endpackage

// File: rtl/instr_ctrl_if.sv
// Bus between the tick/instruction source and the control-word generator.
interface instr_ctrl_if;
    import instr_ctrl_pkg::*;

    logic              run;
    logic [DATA_W-1:0] din;
    logic [3:0]        tick;
    logic              g_nz;

    logic              tick_en;
    logic              tick_clr;
    logic              ir_load;
    logic [NREG-1:0]   rin;
    logic [NREG-1:0]   rout;
    logic              imm_out;
    logic              gout;
    logic              mem_out;
    logic              ain;
    logic              gin;
    logic              alu_sub;
    logic              addr_in;
    logic              dout_in;
    logic              mem_wr;
    logic [DATA_W-1:0] imm16;
    logic              done;
    logic              busy;
    logic              tick_err;

    modport master (
        output run, din, tick, g_nz,
        input  tick_en, tick_clr, ir_load, rin, rout, imm_out, gout, mem_out,
               ain, gin, alu_sub, addr_in, dout_in, mem_wr, imm16, done, busy, tick_err
    );

    modport slave (
        input  run, din, tick, g_nz,
        output tick_en, tick_clr, ir_load, rin, rout, imm_out, gout, mem_out,
               ain, gin, alu_sub, addr_in, dout_in, mem_wr, imm16, done, busy, tick_err
    );

endinterface

// File: rtl/instr_ctrl_dec.sv
// 4-bit index to 16-bit one-hot decoder with enable; all zeros when disabled.
module decoder4to16 (
    input  logic [3:0]  i_idx,
    input  logic        i_en,
    output logic [15:0] o_onehot
);
    assign o_onehot = i_en ? (16'h0001 << i_idx) : 16'h0000;
endmodule

// File: rtl/sign_ext.sv
// Sign extension of an IN_W-bit field to OUT_W bits.
module sign_ext #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_in,
    output logic [OUT_W-1:0] o_out
);
    assign o_out = {{(OUT_W-IN_W){i_in[IN_W-1]}}, i_in};
endmodule

// File: rtl/instr_ctrl.sv
// Instruction register and per-tick control-word generator. Latches the
// instruction at T0, decodes T1..T3 strobes and closes each instruction with done.
module instr_ctrl
    import instr_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    instr_ctrl_if.slave bus
);

    logic [DATA_W-1:0] r_ir;
    logic              r_busy;
    logic              r_tick_err;

    opcode_t    w_op;
    logic [3:0] w_rx;
    logic [3:0] w_ry;
    logic       w_live;
    logic       w_t0;
    logic       w_tick_ok;
    logic [1:0] w_tidx;
    logic       w_illegal;
    logic       w_done;
    logic       w_rin_en;
    logic       w_rout_en;
    logic [3:0] w_rout_sel;

    assign w_op = opcode_t'(r_ir[OP_MSB:OP_LSB]);
    assign w_rx = r_ir[RX_MSB:RX_LSB];
    assign w_ry = r_ir[RY_MSB:RY_LSB];

    // Gating with rst keeps every output quiet while reset is held.
    assign w_live = !rst && (r_busy || bus.run);
    assign w_t0   = w_live && (bus.tick == 4'b0001);

    always_comb begin
        w_tick_ok = 1'b1;
        w_tidx    = T0;
        case (bus.tick)
            4'b0001: w_tidx = T0;
            4'b0010: w_tidx = T1;
            4'b0100: w_tidx = T2;
            4'b1000: w_tidx = T3;
            default: w_tick_ok = 1'b0;
        endcase
    end

    assign w_illegal = !rst && r_busy && (!w_tick_ok || (w_tidx > last_tick(w_op)));

    always_comb begin
        bus.ir_load = 1'b0;
        bus.imm_out = 1'b0;
        bus.gout    = 1'b0;
        bus.mem_out = 1'b0;
        bus.ain     = 1'b0;
        bus.gin     = 1'b0;
        bus.alu_sub = 1'b0;
        bus.addr_in = 1'b0;
        bus.dout_in = 1'b0;
        bus.mem_wr  = 1'b0;
        w_rin_en    = 1'b0;
        w_rout_en   = 1'b0;
        w_rout_sel  = w_ry;
        w_done      = 1'b0;
        if (w_illegal) begin
            w_done = 1'b1;
        end else if (w_t0) begin
            bus.ir_load = 1'b1;
        end else if (w_live && r_busy) begin
            // Legal non-T0 ticks only reach here, so tidx is within 1..last_tick.
            case (w_op)
                OP_MV: begin
                    w_rout_en = 1'b1;
                    w_rin_en  = 1'b1;
                    w_done    = 1'b1;
                end
                OP_MVI: begin
                    bus.imm_out = 1'b1;
                    w_rin_en    = 1'b1;
                    w_done      = 1'b1;
                end
                OP_MVNZ: begin
                    w_rout_en = bus.g_nz;
                    w_rin_en  = bus.g_nz;
                    w_done    = 1'b1;
                end
                OP_ADD, OP_SUB, OP_ADDI: begin
                    case (w_tidx)
                        T1: begin
                            w_rout_sel = w_rx;
                            w_rout_en  = 1'b1;
                            bus.ain    = 1'b1;
                        end
                        T2: begin
                            w_rout_en   = (w_op != OP_ADDI);
                            bus.imm_out = (w_op == OP_ADDI);
                            bus.alu_sub = (w_op == OP_SUB);
                            bus.gin     = 1'b1;
                        end
                        default: begin
                            bus.gout = 1'b1;
                            w_rin_en = 1'b1;
                            w_done   = 1'b1;
                        end
                    endcase
                end
                OP_LD, OP_ST: begin
                    case (w_tidx)
                        T1: begin
                            w_rout_en   = 1'b1;
                            bus.addr_in = 1'b1;
                        end
                        T2: begin
                            if (w_op == OP_ST) begin
                                w_rout_sel  = w_rx;
                                w_rout_en   = 1'b1;
                                bus.dout_in = 1'b1;
                                bus.mem_wr  = 1'b1;
                                w_done      = 1'b1;
                            end
                        end
                        default: begin
                            bus.mem_out = 1'b1;
                            w_rin_en    = 1'b1;
                            w_done      = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    decoder4to16 u_rin_dec (
        .i_idx    (w_rx),
        .i_en     (w_rin_en),
        .o_onehot (bus.rin)
    );

    decoder4to16 u_rout_dec (
        .i_idx    (w_rout_sel),
        .i_en     (w_rout_en),
        .o_onehot (bus.rout)
    );

    sign_ext #(
        .IN_W  (IMM_W),
        .OUT_W (DATA_W)
    ) u_sext (
        .i_in  (r_ir[IMM_W-1:0]),
        .o_out (bus.imm16)
    );

    assign bus.tick_en  = w_live;
    assign bus.tick_clr = w_done;
    assign bus.done     = w_done;
    assign bus.busy     = r_busy;
    assign bus.tick_err = r_tick_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir       <= '0;
            r_busy     <= 1'b0;
            r_tick_err <= 1'b0;
        end else begin
            if (w_t0)
                r_ir <= bus.din;
            if (w_illegal)
                r_tick_err <= 1'b1;
            // A run arriving with done starts the next instruction immediately.
            if (!r_busy)
                r_busy <= bus.run;
            else if (w_done && !bus.run)
                r_busy <= 1'b0;
        end
    end

endmodule
